// File: rtl/writeback_regfile.sv
// writeback_regfile: integer register file with same-cycle writeback bypass and a commit counter.
module writeback_regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int CW   = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteW,
  input  logic [AW-1:0]   RdW,
  input  logic [XLEN-1:0] ResultW,
  input  logic [AW-1:0]   A1,
  input  logic [AW-1:0]   A2,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2,
  input  logic [AW-1:0]   DbgA,
  output logic [XLEN-1:0] DbgRD,
  output logic [CW-1:0]   WrCount
);
  logic [XLEN-1:0] r_regs [NREG];
  logic [CW-1:0]   r_cnt;
  logic            w_we;
  // RegWriteW is tested first so an unknown RdW cannot leak into state when idle
  assign w_we = RegWriteW && (RdW != '0);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      r_cnt <= '0;
    end else if (w_we) begin
      r_regs[RdW] <= ResultW;
      r_cnt       <= r_cnt + CW'(1);
    end
  assign RD1     = (!rst || A1 == '0) ? '0 : (w_we && RdW == A1) ? ResultW : r_regs[A1];
  assign RD2     = (!rst || A2 == '0) ? '0 : (w_we && RdW == A2) ? ResultW : r_regs[A2];
  assign DbgRD   = (!rst || DbgA == '0) ? '0 : r_regs[DbgA];
  assign WrCount = r_cnt;
endmodule

// File: tb/tb_writeback_regfile.sv
// tb_writeback_regfile: randomized scoreboard bench for writeback_regfile, counter built narrow to exercise wrap.
module tb_writeback_regfile;
  localparam int CW = 4;
  logic        clk = 0;
  logic        rst = 0;
  logic        we = 0;
  logic [4:0]  rd = 0, a1 = 0, a2 = 0, dbga = 0;
  logic [31:0] res = 0;
  logic [31:0] rd1, rd2, dbgrd;
  logic [CW-1:0] wrcount;

  writeback_regfile #(.XLEN(32), .NREG(32), .AW(5), .CW(CW)) dut (
    .clk(clk), .rst(rst), .RegWriteW(we), .RdW(rd), .ResultW(res),
    .A1(a1), .A2(a2), .RD1(rd1), .RD2(rd2), .DbgA(dbga), .DbgRD(dbgrd), .WrCount(wrcount)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic [31:0]   rd1, rd2, dbg;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m[32];
  int          mcnt = 0;
  int          vectors = 0;
  int          miscompares = 0;

  function automatic logic [31:0] port_exp(input logic [4:0] a);
    if (!rst || a == 0) return 0;
    if (we && rd != 0 && rd == a) return res;
    return m[a];
  endfunction

  task automatic push(input string name);
    exp_t e;
    e.name = name;
    e.rd1  = port_exp(a1);
    e.rd2  = port_exp(a2);
    e.dbg  = (!rst || dbga == 0) ? 32'h0 : m[dbga];
    e.cnt  = CW'(mcnt);
    sb.push_back(e);
  endtask

  // Caller is just after a posedge; drives, records expectation, then commits the model at the next edge.
  task automatic apply(input logic w, input logic [4:0] d, input logic [31:0] r,
                       input logic [4:0] x1, input logic [4:0] x2, input logic [4:0] xd,
                       input string name);
    we = w; rd = d; res = r; a1 = x1; a2 = x2; dbga = xd;
    push(name);
    @(posedge clk);
    if (rst && w && d != 0) begin
      m[d] = r;
      mcnt = (mcnt + 1) % (1 << CW);
    end
    #1;
  endtask

  task automatic cmp32(input string n, input string f, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s.%s got %h want %h", n, f, act, req);
    end
  endtask

  always @(negedge clk)
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      cmp32(e.name, "RD1", rd1, e.rd1);
      cmp32(e.name, "RD2", rd2, e.rd2);
      cmp32(e.name, "DbgRD", dbgrd, e.dbg);
      cmp32(e.name, "WrCount", 32'(wrcount), 32'(e.cnt));
    end

  initial begin
    for (int i = 0; i < 32; i++) m[i] = 0;
    #1;
    for (int i = 0; i < 3; i++) apply(1, 5, 32'hDEADBEEF, 5, 5, 5, "reset_hold");
    rst = 1;
    apply(0, 0, 0, 5, 0, 5, "reset_release");
    apply(1, 7, 32'h12345678, 0, 0, 0, "basic_wr");
    apply(0, 0, 0, 7, 7, 7, "basic_rd");
    apply(1, 3, 32'h1, 0, 0, 0, "x3_init");
    apply(1, 3, 32'hAAAA0000, 3, 4, 3, "bypass");
    apply(0, 0, 0, 3, 4, 3, "bypass_after");
    apply(1, 0, 32'hFFFFFFFF, 0, 0, 0, "x0_write");
    apply(0, 0, 0, 0, 0, 0, "x0_after");
    for (int i = 0; i < 150; i++)
      apply($urandom_range(0, 3) != 0, 5'($urandom), $urandom, 5'($urandom), 5'($urandom),
            5'($urandom), "random");
    while (mcnt != (1 << CW) - 1) apply(1, 5'($urandom_range(2, 31)), $urandom, 1, 2, 1, "fill");
    apply(1, 1, 32'hC0FFEE01, 1, 1, 1, "wrap_wr");
    apply(0, 0, 0, 1, 0, 1, "wrap_rd");
    for (int i = 1; i < 32; i++) apply(1, 5'(i), 32'(i), 5'(i), 5'(i - 1), 5'(i), "fill_idx");
    apply(0, 0, 0, 31, 17, 9, "pre_reset");
    rst = 0;
    for (int i = 0; i < 32; i++) m[i] = 0;
    mcnt = 0;
    a1 = 31; a2 = 17; dbga = 9;
    push("async_rst");
    @(negedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 32; i += 4) apply(0, 0, 0, 5'(i + 1), 5'(i + 2), 5'(i + 3), "post_rst");
    apply(1, 9, 32'h5A5A5A5A, 9, 0, 9, "post_rst_wr");
    apply(0, 0, 0, 9, 9, 9, "post_rst_rd");
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain got %0d left want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/writeback_regfile.md
Name: writeback_regfile

Overview:
Integer register file at the receiving end of the writeback path. It accepts the writeback result (ResultW, RdW, RegWriteW) and serves the two decode-stage read ports. Same-cycle writeback-to-read bypass is built in, so the decode stage never observes a stale value during the cycle a register is written. A saturating-free retire-write counter records how many architectural register writes have been committed. The counter supports debug and performance monitoring.

Parameters:
XLEN, 32, data width of each register and of all data ports
NREG, 32, number of architectural registers; index 0 is hardwired zero
AW, 5, register index width; must satisfy 2**AW == NREG
CW, 32, width of the write counter

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous active-low reset
RegWriteW  input  1  writeback write enable
RdW  input  AW  writeback destination register index
ResultW  input  XLEN  writeback data
A1  input  AW  decode read port 1 index (rs1)
A2  input  AW  decode read port 2 index (rs2)
RD1  output  XLEN  read data port 1
RD2  output  XLEN  read data port 2
DbgA  input  AW  debug read index
DbgRD  output  XLEN  debug read data, no bypass
WrCount  output  CW  count of committed non-x0 writes

Behaviour:
- Reset: rst low asynchronously clears all NREG registers to 0 and WrCount to 0. While rst is low, RD1, RD2 and DbgRD read 0 for every index, and no write occurs on clock edges.
- Write: on a rising clk edge, the write occurs when rst is high, RegWriteW is 1 and RdW != 0. reg[RdW] <= ResultW. WrCount <= WrCount + 1 on that same edge.
- x0: a write with RdW == 0 is discarded. WrCount does not increment. Reads of index 0 always return 0 on every port, including when RegWriteW=1 and RdW=0.
- Read (RD1/RD2): combinational, zero latency, from the current array contents.
- Bypass on RD1/RD2: if RegWriteW=1, RdW != 0 and RdW == A1, then RD1 = ResultW. The same rule applies for A2 and RD2. Both ports may bypass simultaneously when A1 == A2 == RdW.
- DbgRD: combinational array read only, with no bypass. It shows the old value until the write edge.
- WrCount: wraps modulo 2**CW, so all-ones + 1 gives 0. No sticky overflow flag.
- Reset mid-operation: asserting rst in the same cycle as a pending write cancels the write. The array reads 0 afterwards. On rst deassertion, the first rising edge with rst high is the first edge that can commit a write.
- Unknown or X on RdW with RegWriteW=0 must not affect state. Implementation must gate the write on RegWriteW first.
- No other internal state. The block is purely register array, bypass muxing and counter.

Test Plan:
- Reset check: hold rst=0, clock 3 cycles with RegWriteW=1, RdW=5, ResultW=32'hDEADBEEF. Then release rst. Required: DbgA=5 gives 0, WrCount=0, RD1 with A1=5 gives 0.
- Basic write/read: write x7=32'h12345678 on one edge, then set A1=7, A2=7. Required: RD1=RD2=32'h12345678, DbgRD=32'h12345678 at DbgA=7, WrCount=1.
- Bypass: x3 holds 32'h1. Drive RegWriteW=1, RdW=3, ResultW=32'hAAAA0000 with A1=3, A2=4. Required before the edge: RD1=32'hAAAA0000, RD2=old x4, DbgRD at DbgA=3 = 32'h1. After the edge: DbgRD=32'hAAAA0000.
- x0 discipline: drive RegWriteW=1, RdW=0, ResultW=32'hFFFFFFFF with A1=0. Required: RD1=0 before and after the edge, DbgRD at index 0 = 0, WrCount unchanged.
- Counter wrap: preload by 2**CW-1 writes, or use CW=4 with 15 writes. Then do one more write to x1. Required: WrCount=0, x1 updated.
- Async reset mid-run: after writing x1..x31 with index value i, pulse rst low for a half cycle between edges. Required: all registers read 0 immediately without a clock edge, WrCount=0, and a write on the next edge after release succeeds with WrCount=1.
